// File: rtl/apu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apu_pkg
// Description : Shared constants, types and helpers for the APU noise-channel
//               register file and its frame sequencer.
//               - Register offsets (relative to $4000) decoded from the host bus
//               - Frame-sequencer mode encodings
//               - Per-step strobe/IRQ decode and step advance helpers
// Revision    : 1.0 - initial release
// ============================================================================
package apu_pkg;

    localparam logic [4:0] ADDR_NOISE_VOL = 5'h0C;
    localparam logic [4:0] ADDR_NOISE_PER = 5'h0E;
    localparam logic [4:0] ADDR_NOISE_LEN = 5'h0F;
    localparam logic [4:0] ADDR_STATUS    = 5'h15;
    localparam logic [4:0] ADDR_FRAME     = 5'h17;

    localparam logic MODE_4STEP = 1'b0;
    localparam logic MODE_5STEP = 1'b1;

    // What a step produces when it completes.
    typedef struct packed {
        logic q240;   // quarter-frame strobe
        logic h120;   // half-frame strobe
        logic irq;    // request to set frame_irq (still gated by inhibit)
    } step_action_t;

    function automatic step_action_t step_decode(input logic mode, input logic [2:0] step);
        step_action_t act;
        act = '0;
        if (mode == MODE_4STEP) begin
            act.q240 = 1'b1;
            act.h120 = (step == 3'd1) || (step == 3'd3);
            act.irq  = (step == 3'd3);
        end else begin
            case (step)
                3'd0:    act.q240 = 1'b1;
                3'd1:    begin act.q240 = 1'b1; act.h120 = 1'b1; end
                3'd2:    act.q240 = 1'b1;
                3'd4:    begin act.q240 = 1'b1; act.h120 = 1'b1; end
                default: act = '0;
            endcase
        end
        return act;
    endfunction

    function automatic logic [2:0] step_next(input logic mode, input logic [2:0] step);
        logic [2:0] last;
        last = (mode == MODE_5STEP) ? 3'd4 : 3'd3;
        return (step >= last) ? 3'd0 : step + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : apu_frame_sequencer
// Description : Divider, step counter, 240/120 Hz strobes and frame IRQ.
//               A frame write (1-cycle pulse) restarts the sequence at step 0
//               with a full divider period and always wins over a coincident
//               divider expiry.
// Ports       : clk, rst            - clock, async active-high reset
//               i_frame_write       - 1-cycle pulse: $4017 written
//               i_mode              - new mode (data[7])
//               i_irq_inhibit       - new inhibit (data[6])
//               o_enable_240hz      - 1-cycle quarter-frame strobe
//               o_enable_120hz      - 1-cycle half-frame strobe
//               o_frame_irq         - level frame interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int DIVIDER = 7457
) (
    input  logic clk,
    input  logic rst,
    input  logic i_frame_write,
    input  logic i_mode,
    input  logic i_irq_inhibit,
    output logic o_enable_240hz,
    output logic o_enable_120hz,
    output logic o_frame_irq
);

    localparam int               DIV_W        = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] c_DIV_RELOAD = DIV_W'(DIVIDER - 1);

    logic [DIV_W-1:0] r_divider;
    logic [2:0]       r_step;
    logic             r_mode;
    logic             r_irq_inhibit;
    logic             r_enable_240hz;
    logic             r_enable_120hz;
    logic             r_frame_irq;

    step_action_t     w_act;

    assign w_act = step_decode(r_mode, r_step);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divider      <= c_DIV_RELOAD;
            r_step         <= 3'd0;
            r_mode         <= MODE_4STEP;
            r_irq_inhibit  <= 1'b0;
            r_enable_240hz <= 1'b0;
            r_enable_120hz <= 1'b0;
            r_frame_irq    <= 1'b0;
        end else if (i_frame_write) begin
            // Restart from step 0; any coincident expiry is discarded.
            r_divider      <= c_DIV_RELOAD;
            r_step         <= 3'd0;
            r_mode         <= i_mode;
            r_irq_inhibit  <= i_irq_inhibit;
            r_enable_240hz <= i_mode;
            r_enable_120hz <= i_mode;
            if (i_irq_inhibit) begin
                r_frame_irq <= 1'b0;
            end
        end else if (r_divider == '0) begin
            r_divider      <= c_DIV_RELOAD;
            r_step         <= step_next(r_mode, r_step);
            r_enable_240hz <= w_act.q240;
            r_enable_120hz <= w_act.h120;
            if (w_act.irq && !r_irq_inhibit) begin
                r_frame_irq <= 1'b1;
            end
        end else begin
            r_divider      <= r_divider - 1'b1;
            r_enable_240hz <= 1'b0;
            r_enable_120hz <= 1'b0;
        end
    end

    assign o_enable_240hz = r_enable_240hz;
    assign o_enable_120hz = r_enable_120hz;
    assign o_frame_irq    = r_frame_irq;

endmodule
`default_nettype wire

// File: rtl/apu_register_file.sv
`default_nettype none
// ============================================================================
// Module      : apu_register_file
// Description : Host-side write port and frame sequencer for the APU noise
//               channel. Decodes byte writes into $400C/$400E/$400F, the
//               $4015 noise enable and $4017 frame control, and emits the
//               $400F load event and frame-sequencer strobes/IRQ.
// Ports       : clk, rst                 - clock, async active-high reset
//               i_wr_valid / o_wr_ready  - write handshake (ready drops 1 cycle
//                                          after every accepted write)
//               i_wr_addr [4:0]          - offset from $4000
//               i_wr_data [7:0]          - write data
//               o_reg_400C/E/F [7:0]     - noise channel registers
//               o_reg_event              - 1-cycle strobe, $400F written
//               o_noise_enable           - $4015 bit 3
//               o_enable_240hz/120hz     - frame strobes
//               o_frame_irq              - level frame interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module apu_register_file
    import apu_pkg::*;
#(
    parameter int DIVIDER = 7457
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [4:0] i_wr_addr,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_reg_400C,
    output logic [7:0] o_reg_400E,
    output logic [7:0] o_reg_400F,
    output logic       o_reg_event,
    output logic       o_noise_enable,
    output logic       o_enable_240hz,
    output logic       o_enable_120hz,
    output logic       o_frame_irq
);

    logic       r_wr_ready;
    logic [7:0] r_reg_400C;
    logic [7:0] r_reg_400E;
    logic [7:0] r_reg_400F;
    logic       r_reg_event;
    logic       r_noise_enable;

    logic       w_accept;
    logic       w_frame_write;

    assign w_accept      = i_wr_valid && r_wr_ready;
    assign w_frame_write = w_accept && (i_wr_addr == ADDR_FRAME);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ready     <= 1'b1;
            r_reg_400C     <= 8'h00;
            r_reg_400E     <= 8'h00;
            r_reg_400F     <= 8'h00;
            r_reg_event    <= 1'b0;
            r_noise_enable <= 1'b0;
        end else begin
            // Ready is low for exactly the cycle following an accept.
            r_wr_ready  <= !w_accept;
            r_reg_event <= w_accept && (i_wr_addr == ADDR_NOISE_LEN);
            if (w_accept) begin
                case (i_wr_addr)
                    ADDR_NOISE_VOL: r_reg_400C     <= i_wr_data;
                    ADDR_NOISE_PER: r_reg_400E     <= i_wr_data;
                    ADDR_NOISE_LEN: r_reg_400F     <= i_wr_data;
                    ADDR_STATUS:    r_noise_enable <= i_wr_data[3];
                    default:        ;
                endcase
            end
        end
    end

    apu_frame_sequencer #(
        .DIVIDER (DIVIDER)
    ) u_frame_sequencer (
        .clk            (clk),
        .rst            (rst),
        .i_frame_write  (w_frame_write),
        .i_mode         (i_wr_data[7]),
        .i_irq_inhibit  (i_wr_data[6]),
        .o_enable_240hz (o_enable_240hz),
        .o_enable_120hz (o_enable_120hz),
        .o_frame_irq    (o_frame_irq)
    );

    assign o_wr_ready     = r_wr_ready;
    assign o_reg_400C     = r_reg_400C;
    assign o_reg_400E     = r_reg_400E;
    assign o_reg_400F     = r_reg_400F;
    assign o_reg_event    = r_reg_event;
    assign o_noise_enable = r_noise_enable;

endmodule
`default_nettype wire

// File: tb/tb_apu_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_apu_register_file
// Description : Directed self-checking bench for apu_register_file with a
//               short divider (DIVIDER=4) so frame timing is easy to follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apu_register_file;

    localparam int DIVIDER = 4;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] reg_400C;
    logic [7:0] reg_400E;
    logic [7:0] reg_400F;
    logic       reg_event;
    logic       noise_enable;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       frame_irq;

    int n_cmp = 0;
    int n_bad = 0;

    apu_register_file #(
        .DIVIDER (DIVIDER)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .o_reg_400C     (reg_400C),
        .o_reg_400E     (reg_400E),
        .o_reg_400F     (reg_400F),
        .o_reg_event    (reg_event),
        .o_noise_enable (noise_enable),
        .o_enable_240hz (enable_240hz),
        .o_enable_120hz (enable_120hz),
        .o_frame_irq    (frame_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_strobes(input string tag, input logic e240, input logic e120, input logic eirq);
        check({tag, "_240"}, {7'd0, enable_240hz}, {7'd0, e240});
        check({tag, "_120"}, {7'd0, enable_120hz}, {7'd0, e120});
        check({tag, "_irq"}, {7'd0, frame_irq},    {7'd0, eirq});
    endtask

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = 5'h00;
        wr_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_ready", {7'd0, wr_ready}, 8'h01);
        check("rst_400C", reg_400C, 8'h00);
        check("rst_400E", reg_400E, 8'h00);
        check("rst_400F", reg_400F, 8'h00);
        check("rst_event", {7'd0, reg_event}, 8'h00);
        check("rst_nen", {7'd0, noise_enable}, 8'h00);
        check_strobes("rst", 1'b0, 1'b0, 1'b0);

        // Mode 0 free run: 240 every 4 edges, 120 every 8, IRQ at 4th strobe
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check_strobes($sformatf("m0_k%0d", k), (k % 4) == 0, (k % 8) == 0, k == 16);
        end

        // $0C write, then $0F held valid through the not-ready cycle
        wr_valid = 1'b1; wr_addr = 5'h0C; wr_data = 8'h3F;
        tick();
        check("w0C_val", reg_400C, 8'h3F);
        check("w0C_ready", {7'd0, wr_ready}, 8'h00);
        check("w0C_event", {7'd0, reg_event}, 8'h00);
        wr_addr = 5'h0F; wr_data = 8'h08;
        tick();
        check("w0F_blocked_ready", {7'd0, wr_ready}, 8'h01);
        check("w0F_blocked_val", reg_400F, 8'h00);
        check("w0F_blocked_event", {7'd0, reg_event}, 8'h00);
        tick();
        check("w0F_val", reg_400F, 8'h08);
        check("w0F_event", {7'd0, reg_event}, 8'h01);
        check("w0F_ready", {7'd0, wr_ready}, 8'h00);
        wr_valid = 1'b0;
        tick();
        check("w0F_event_end", {7'd0, reg_event}, 8'h00);
        check("w0F_ready_back", {7'd0, wr_ready}, 8'h01);

        // $0E, $15 and an unmapped address
        wr_valid = 1'b1; wr_addr = 5'h0E; wr_data = 8'h55;
        tick();
        wr_valid = 1'b0;
        check("w0E_val", reg_400E, 8'h55);
        tick();
        wr_valid = 1'b1; wr_addr = 5'h15; wr_data = 8'h08;
        tick();
        wr_valid = 1'b0;
        check("w15_nen", {7'd0, noise_enable}, 8'h01);
        tick();
        wr_valid = 1'b1; wr_addr = 5'h03; wr_data = 8'hFF;
        tick();
        wr_valid = 1'b0;
        check("w03_ready", {7'd0, wr_ready}, 8'h00);
        check("w03_400C", reg_400C, 8'h3F);
        check("w03_400E", reg_400E, 8'h55);
        check("w03_400F", reg_400F, 8'h08);
        check("w03_event", {7'd0, reg_event}, 8'h00);
        check("irq_held", {7'd0, frame_irq}, 8'h01);
        tick();

        // $17 = 0xC0: 5-step mode, clear IRQ, immediate double strobe
        wr_valid = 1'b1; wr_addr = 5'h17; wr_data = 8'hC0;
        tick();
        wr_valid = 1'b0;
        check_strobes("w17_C0", 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            int  s;
            logic e240;
            logic e120;
            tick();
            s    = (k / 4 - 1) % 5;
            e240 = ((k % 4) == 0) && (s != 3);
            e120 = ((k % 4) == 0) && ((s == 1) || (s == 4));
            check_strobes($sformatf("m1_k%0d", k), e240, e120, 1'b0);
        end

        // $17 = 0x00: back to 4-step, no immediate strobe, IRQ at step 3
        wr_valid = 1'b1; wr_addr = 5'h17; wr_data = 8'h00;
        tick();
        wr_valid = 1'b0;
        check_strobes("w17_00", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 15; k++) tick();
        check("irq_pre", {7'd0, frame_irq}, 8'h00);
        tick();
        check_strobes("m0_step3", 1'b1, 1'b1, 1'b1);
        repeat (3) tick();

        // $17 = 0x40 exactly on the divider==0 edge: write wins
        wr_valid = 1'b1; wr_addr = 5'h17; wr_data = 8'h40;
        tick();
        wr_valid = 1'b0;
        check_strobes("w17_40_collide", 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_strobes($sformatf("after40_k%0d", k), k == 4, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a step
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_400C", reg_400C, 8'h00);
        check("arst_400E", reg_400E, 8'h00);
        check("arst_400F", reg_400F, 8'h00);
        check("arst_nen", {7'd0, noise_enable}, 8'h00);
        check("arst_ready", {7'd0, wr_ready}, 8'h01);
        check_strobes("arst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_strobes($sformatf("postrst_k%0d", k), (k % 4) == 0, k == 8, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
